// File: rtl/msrv32_lu_pkg.sv
// msrv32_lu_pkg: load-size codes, FSM states and default bus timeout for the load unit
package msrv32_lu_pkg;
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;
  localparam int LU_TIMEOUT_CYCLES = 16;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} lu_state_t;
endpackage

// File: rtl/msrv32_lu_extend.sv
// msrv32_lu_extend: byte/half lane select and sign or zero extension of a loaded word
module msrv32_lu_extend
  import msrv32_lu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  // pick the addressed byte and half, then extend by size; size 11 falls through as a word
  always_comb begin
    b = lane[1] ? (lane[0] ? rdata[31:24] : rdata[23:16]) : (lane[0] ? rdata[15:8] : rdata[7:0]);
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    result = size == LS_BYTE ? {{24{~uns & b[7]}}, b} :
             size == LS_HALF ? {{16{~uns & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/msrv32_load_unit.sv
// msrv32_load_unit: ready/valid data-memory load FSM with stall, misalign and optional timeout (MSRV32_LU_TIMEOUT_EN)
module msrv32_load_unit
  import msrv32_lu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = LU_TIMEOUT_CYCLES
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              load_req_in,
  input  logic [1:0]        load_size_in,
  input  logic              load_unsigned_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              flush_in,
  output logic              dmem_req_out,
  output logic [ADDR_W-1:0] dmem_addr_out,
  input  logic              dmem_ready_in,
  input  logic              dmem_valid_in,
  input  logic [31:0]       dmem_rdata_in,
  output logic [31:0]       lu_output_out,
  output logic              lu_valid_out,
  output logic              stall_out,
  output logic              misaligned_out,
  output logic              access_fault_out
);
  lu_state_t   state;
  logic [1:0]  lane_q, size_q;
  logic        uns_q, go, mis, to;
  logic [31:0] ext;

  assign mis = load_size_in[1] ? |addr_in[1:0] : (load_size_in[0] & addr_in[0]);
  assign go = state == IDLE && load_req_in && !flush_in;
  assign stall_out = (go && !mis) || state == REQ || state == WAIT;
  assign dmem_req_out = state == REQ;
  assign lu_valid_out = state == DONE;

  msrv32_lu_extend u_ext (
    .rdata (dmem_rdata_in),
    .lane  (lane_q),
    .size  (size_q),
    .uns   (uns_q),
    .result(ext)
  );

`ifdef MSRV32_LU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign to = cnt == CW'(TIMEOUT_CYCLES - 1);
  // cycles spent in REQ+WAIT since the request was accepted; fault pulses when the limit expires
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt <= '0;
      access_fault_out <= 1'b0;
    end else begin
      access_fault_out <= to && !flush_in &&
                          ((state == REQ && !dmem_ready_in) || (state == WAIT && !dmem_valid_in));
      cnt <= (go && !mis) ? '0 : (state == REQ || state == WAIT) ? cnt + 1'b1 : cnt;
    end
  end
`else
  assign to = 1'b0;
  assign access_fault_out = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // load sequencing: capture request, handshake the bus, register the extended result
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= IDLE;
      dmem_addr_out <= '0;
      lane_q <= 2'b00;
      size_q <= 2'b00;
      uns_q <= 1'b0;
      lu_output_out <= 32'h0;
      misaligned_out <= 1'b0;
    end else begin
      misaligned_out <= go && mis;
      case (state)
        IDLE: if (go && !mis) begin
          state <= REQ;
          dmem_addr_out <= {addr_in[ADDR_W-1:2], 2'b00};
          lane_q <= addr_in[1:0];
          size_q <= load_size_in;
          uns_q <= load_unsigned_in;
        end
        REQ: state <= flush_in ? (dmem_ready_in ? DRAIN : IDLE) :
                      dmem_ready_in ? WAIT : to ? IDLE : REQ;
        WAIT: begin
          state <= flush_in ? (dmem_valid_in ? IDLE : DRAIN) :
                   dmem_valid_in ? DONE : to ? DRAIN : WAIT;
          if (!flush_in && dmem_valid_in) lu_output_out <= ext;
        end
        DONE: state <= IDLE;
        DRAIN: if (dmem_valid_in) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msrv32_load_unit.sv
// tb_msrv32_load_unit: table-driven load vectors plus flush, reset and timeout sequences
module tb_msrv32_load_unit;
  import msrv32_lu_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        load_req_in = 1'b0;
  logic [1:0]  load_size_in = 2'b00;
  logic        load_unsigned_in = 1'b0;
  logic [31:0] addr_in = 32'h0;
  logic        flush_in = 1'b0;
  logic        dmem_ready_in = 1'b0;
  logic        dmem_valid_in = 1'b0;
  logic [31:0] dmem_rdata_in = 32'h0;
  logic        dmem_req_out, lu_valid_out, stall_out, misaligned_out, access_fault_out;
  logic [31:0] dmem_addr_out, lu_output_out;

  msrv32_load_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .load_req_in(load_req_in), .load_size_in(load_size_in),
    .load_unsigned_in(load_unsigned_in), .addr_in(addr_in), .flush_in(flush_in),
    .dmem_req_out(dmem_req_out), .dmem_addr_out(dmem_addr_out), .dmem_ready_in(dmem_ready_in),
    .dmem_valid_in(dmem_valid_in), .dmem_rdata_in(dmem_rdata_in), .lu_output_out(lu_output_out),
    .lu_valid_out(lu_valid_out), .stall_out(stall_out), .misaligned_out(misaligned_out),
    .access_fault_out(access_fault_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rdata;
    int          rdly;
    int          vdly;
    logic        mis;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[15];
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_load(input vec_t v, output int vcyc, output int nvalid, output int nmis,
                          output int nreq, output int nfault, output bit addr_ok, output bit stall_ok);
    int hs, expv;
    expv = v.mis ? -1 : 3 + v.rdly + v.vdly;
    hs = -1; vcyc = -1; nvalid = 0; nmis = 0; nreq = 0; nfault = 0; addr_ok = 1; stall_ok = 1;
    for (int c = 0; c < 16 + v.rdly + v.vdly; c++) begin
      step();
      load_req_in = (c == 0);
      load_size_in = v.size;
      load_unsigned_in = v.uns;
      addr_in = v.addr;
      dmem_ready_in = 1'b0;
      if (dmem_req_out) begin
        nreq++;
        if (dmem_addr_out !== {v.addr[31:2], 2'b00}) addr_ok = 0;
        dmem_ready_in = nreq > v.rdly;
        if (dmem_ready_in) hs = c;
      end
      dmem_valid_in = hs >= 0 && c == hs + 1 + v.vdly;
      dmem_rdata_in = dmem_valid_in ? v.rdata : ~v.rdata;
      #1;
      if (lu_valid_out) begin
        nvalid++;
        if (vcyc < 0) vcyc = c;
      end
      nmis += int'(misaligned_out);
      nfault += int'(access_fault_out);
      if (stall_out !== (c < expv)) stall_ok = 0;
    end
    load_req_in = 1'b0;
    dmem_ready_in = 1'b0;
    dmem_valid_in = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcyc, nvalid, nmis, nreq, nfault, cnt_req, cnt_fault, fault_cyc;
    bit addr_ok, stall_ok, stall_drop;
    vt[0]  = '{LS_BYTE, 1'b0, 32'h0000_1003, 32'h80AA_BBCC, 0, 0, 1'b0, 32'hFFFF_FF80};
    vt[1]  = '{LS_HALF, 1'b1, 32'h0000_2002, 32'h9234_5678, 1, 0, 1'b0, 32'h0000_9234};
    vt[2]  = '{LS_HALF, 1'b0, 32'h0000_2002, 32'h9234_5678, 0, 1, 1'b0, 32'hFFFF_9234};
    vt[3]  = '{LS_WORD, 1'b0, 32'h0000_3002, 32'h1111_1111, 0, 0, 1'b1, 32'hFFFF_9234};
    vt[4]  = '{LS_BYTE, 1'b1, 32'h0000_1001, 32'h80AA_BBCC, 0, 0, 1'b0, 32'h0000_00BB};
    vt[5]  = '{LS_BYTE, 1'b0, 32'h0000_1001, 32'h80AA_BBCC, 2, 0, 1'b0, 32'hFFFF_FFBB};
    vt[6]  = '{LS_HALF, 1'b0, 32'h0000_0010, 32'h1234_7FFF, 0, 0, 1'b0, 32'h0000_7FFF};
    vt[7]  = '{LS_HALF, 1'b0, 32'h0000_0012, 32'h8001_0000, 0, 0, 1'b0, 32'hFFFF_8001};
    vt[8]  = '{LS_BYTE, 1'b0, 32'h0000_0000, 32'h0000_007F, 0, 0, 1'b0, 32'h0000_007F};
    vt[9]  = '{LS_BYTE, 1'b0, 32'h0000_0002, 32'h00FF_0000, 0, 0, 1'b0, 32'hFFFF_FFFF};
    vt[10] = '{LS_HALF, 1'b0, 32'h0000_0005, 32'h2222_2222, 0, 0, 1'b1, 32'hFFFF_FFFF};
    vt[11] = '{2'b11,   1'b0, 32'h0000_0020, 32'hCAFE_F00D, 0, 0, 1'b0, 32'hCAFE_F00D};
    vt[12] = '{LS_WORD, 1'b0, 32'h0000_4000, 32'h1357_9BDF, 5, 2, 1'b0, 32'h1357_9BDF};
    vt[13] = '{2'b11,   1'b0, 32'h0000_0021, 32'h3333_3333, 0, 0, 1'b1, 32'h1357_9BDF};
    vt[14] = '{LS_WORD, 1'b1, 32'h0000_0008, 32'h8000_0000, 0, 0, 1'b0, 32'h8000_0000};

    step(); step(); step();
    chk("reset lu_output", lu_output_out, 32'h0);
    chk("reset dmem_addr", dmem_addr_out, 32'h0);
    chk("reset outputs", {dmem_req_out, lu_valid_out, stall_out, misaligned_out, access_fault_out}, 32'h0);
    rst_in = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_load(vt[i], vcyc, nvalid, nmis, nreq, nfault, addr_ok, stall_ok);
      chk($sformatf("v%0d lu_output", i), lu_output_out, vt[i].exp);
      chk($sformatf("v%0d valid_count", i), nvalid, vt[i].mis ? 0 : 1);
      chk($sformatf("v%0d misaligned_count", i), nmis, vt[i].mis ? 1 : 0);
      chk($sformatf("v%0d req_cycles", i), nreq, vt[i].mis ? 0 : vt[i].rdly + 1);
      chk($sformatf("v%0d stall_pattern", i), stall_ok, 1);
      chk($sformatf("v%0d addr_stable", i), addr_ok, 1);
      chk($sformatf("v%0d fault_count", i), nfault, 0);
      if (!vt[i].mis) chk($sformatf("v%0d valid_cycle", i), vcyc, 3 + vt[i].rdly + vt[i].vdly);
    end
    exp_prev = 32'h8000_0000;

    // flush in WAIT, late valid is drained
    step(); load_req_in = 1'b1; load_size_in = LS_WORD; addr_in = 32'h50;
    step(); load_req_in = 1'b0; dmem_ready_in = 1'b1;
    chk("fw req", dmem_req_out, 1);
    step(); dmem_ready_in = 1'b0; flush_in = 1'b1;
    chk("fw stall in wait", stall_out, 1);
    step(); flush_in = 1'b0;
    chk("fw drain stall", stall_out, 0);
    step(); dmem_valid_in = 1'b1; dmem_rdata_in = 32'hDEAD_BEEF;
    chk("fw drain no valid", lu_valid_out, 0);
    step(); dmem_valid_in = 1'b0;
    chk("fw after no valid", lu_valid_out, 0);
    chk("fw lu_output kept", lu_output_out, exp_prev);
    run_load(vt[4], vcyc, nvalid, nmis, nreq, nfault, addr_ok, stall_ok);
    chk("fw next load stall", stall_ok, 1);
    chk("fw next load out", lu_output_out, 32'h0000_00BB);
    exp_prev = 32'h0000_00BB;

    // flush in WAIT with simultaneous valid goes straight to IDLE
    step(); load_req_in = 1'b1; load_size_in = LS_WORD; addr_in = 32'h54;
    step(); load_req_in = 1'b0; dmem_ready_in = 1'b1;
    step(); dmem_ready_in = 1'b0; flush_in = 1'b1; dmem_valid_in = 1'b1; dmem_rdata_in = 32'h5555_AAAA;
    step(); flush_in = 1'b0; dmem_valid_in = 1'b0;
    chk("fwv no valid", lu_valid_out, 0);
    chk("fwv lu_output kept", lu_output_out, exp_prev);
    run_load(vt[6], vcyc, nvalid, nmis, nreq, nfault, addr_ok, stall_ok);
    chk("fwv idle stall", stall_ok, 1);
    chk("fwv next valid cycle", vcyc, 3);
    exp_prev = 32'h0000_7FFF;

    // flush in REQ without ready returns to IDLE
    step(); load_req_in = 1'b1; load_size_in = LS_WORD; addr_in = 32'h60;
    step(); load_req_in = 1'b0; flush_in = 1'b1;
    chk("fr req", dmem_req_out, 1);
    step(); flush_in = 1'b0;
    chk("fr req dropped", dmem_req_out, 0);
    chk("fr stall dropped", stall_out, 0);

    // flush in REQ with ready drains; load_req in DRAIN ignored
    step(); load_req_in = 1'b1; load_size_in = LS_WORD; addr_in = 32'h64;
    step(); load_req_in = 1'b0; flush_in = 1'b1; dmem_ready_in = 1'b1;
    step(); flush_in = 1'b0; dmem_ready_in = 1'b0; load_req_in = 1'b1;
    chk("frr drain stall", stall_out, 0);
    step(); load_req_in = 1'b0; dmem_valid_in = 1'b1; dmem_rdata_in = 32'h1111_1111;
    chk("frr drain no req", dmem_req_out, 0);
    step(); dmem_valid_in = 1'b0;
    chk("frr no valid", lu_valid_out, 0);
    chk("frr lu_output kept", lu_output_out, exp_prev);
    step();
    chk("frr ignored req", dmem_req_out, 0);

    // flush in IDLE suppresses a request
    step(); load_req_in = 1'b1; flush_in = 1'b1; load_size_in = LS_WORD; addr_in = 32'h68;
    step(); load_req_in = 1'b0; flush_in = 1'b0;
    chk("fi no req", dmem_req_out, 0);

    // reset mid-WAIT clears outputs, late valid ignored
    step(); load_req_in = 1'b1; load_size_in = LS_WORD; addr_in = 32'h70;
    step(); load_req_in = 1'b0; dmem_ready_in = 1'b1;
    step(); dmem_ready_in = 1'b0; rst_in = 1'b0;
    step(); rst_in = 1'b1; dmem_valid_in = 1'b1; dmem_rdata_in = 32'h7777_7777;
    chk("rst lu_output", lu_output_out, 32'h0);
    chk("rst dmem_addr", dmem_addr_out, 32'h0);
    chk("rst outputs", {dmem_req_out, lu_valid_out, stall_out, misaligned_out, access_fault_out}, 32'h0);
    step(); dmem_valid_in = 1'b0;
    chk("rst late valid", lu_valid_out, 0);
    chk("rst late output", lu_output_out, 32'h0);

    // bus never ready
    step(); load_req_in = 1'b1; load_size_in = LS_WORD; addr_in = 32'h80;
    cnt_req = 0; cnt_fault = 0; fault_cyc = -1; stall_drop = 0;
    for (int c = 1; c <= 40; c++) begin
      step(); load_req_in = 1'b0;
      cnt_req += int'(dmem_req_out);
      cnt_fault += int'(access_fault_out);
      if (access_fault_out && fault_cyc < 0) begin
        fault_cyc = c;
        stall_drop = !stall_out;
      end
    end
`ifdef MSRV32_LU_TIMEOUT_EN
    chk("to req cycles", cnt_req, 16);
    chk("to fault count", cnt_fault, 1);
    chk("to fault cycle", fault_cyc, 17);
    chk("to stall dropped", stall_drop, 1);
    chk("to lu_output kept", lu_output_out, 32'h0);
`else
    chk("nto req cycles", cnt_req, 40);
    chk("nto fault count", cnt_fault, 0);
    flush_in = 1'b1;
    step(); flush_in = 1'b0;
    chk("nto flushed", dmem_req_out, 0);
`endif
    chk("end idle stall", stall_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
